// File: rtl/alu_rr_arbiter_pkg.sv
// Shared ALU definitions for the round-robin ALU arbiter: opcodes, opcode type
// and the combinational evaluation function returning {carry, result}.
package alu_pkg;

  localparam int ALU_MAX_W = 8;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD = 3'd0;
  localparam alu_op_t OP_SUB = 3'd1;
  localparam alu_op_t OP_AND = 3'd2;
  localparam alu_op_t OP_OR  = 3'd3;
  localparam alu_op_t OP_NOT = 3'd4;

  // Operands are zero-extended to ALU_MAX_W; w is the live datapath width.
  function automatic logic [ALU_MAX_W:0] alu_eval(
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b,
    input alu_op_t              op,
    input int                   w
  );
    logic [ALU_MAX_W:0]   full;
    logic [ALU_MAX_W-1:0] mask;
    logic                 carry;
    mask  = ALU_MAX_W'((1 << w) - 1);
    full  = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[ALU_MAX_W] | (|(full[ALU_MAX_W-1:0] & ~mask));
      end
      OP_SUB: begin
        full  = {1'b0, a} - {1'b0, b};
        carry = (a < b);
      end
      OP_AND:  full = {1'b0, a & b};
      OP_OR:   full = {1'b0, a | b};
      OP_NOT:  full = {1'b0, ~a};
      default: full = '0;
    endcase
    return {carry, full[ALU_MAX_W-1:0] & mask};
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Round-robin pick: rotates req_valid to start just after ptr, priority-encodes
// the lowest set bit and maps it back to an absolute requester index.
module alu_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win,
  output logic            any_valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                start;
  int                sel;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no latch is inferred.
    start     = (int'(ptr) + 1) % NREQ;
    dbl       = {valid, valid};
    rot       = NREQ'(dbl >> start);
    any_valid = |valid;
    sel       = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) sel = j;
    end
    win = IDW'((start + sel) % NREQ);
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters with a single-entry
// response slot. Optional statistics ports under ALU_RR_ARBITER_STATS_EN.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry
`ifdef ALU_RR_ARBITER_STATS_EN
  ,
  output logic [NREQ*8-1:0]     stat_grants,
  output logic [7:0]            stat_stall
`endif
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]         state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     win;
  logic               any_valid;
  logic               accept_ok;
  logic               transfer;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  alu_op_t            op_sel;
  logic [ALU_MAX_W:0] eval;
  logic               unused_eval;

  alu_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (ptr),
    .win       (win),
    .any_valid (any_valid)
  );

  assign rsp_valid = (state == S_FULL);
  // The slot may be refilled in the same cycle the consumer drains it.
  assign accept_ok = !rsp_valid || rsp_ready;
  assign transfer  = any_valid && accept_ok;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[win] = 1'b1;
    a_sel  = req_a[win*WIDTH +: WIDTH];
    b_sel  = req_b[win*WIDTH +: WIDTH];
    op_sel = req_op[win*3 +: 3];
    eval   = alu_eval(ALU_MAX_W'(a_sel), ALU_MAX_W'(b_sel), op_sel, WIDTH);
  end

  assign unused_eval = ^eval;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on clk.
    if (!rst_n) begin
      state      <= S_EMPTY;
      ptr        <= IDW'(NREQ - 1);
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else if (transfer) begin
      state      <= S_FULL;
      ptr        <= win;
      rsp_id     <= win;
      rsp_result <= eval[WIDTH-1:0];
      rsp_carry  <= eval[ALU_MAX_W];
    end else if (rsp_ready) begin
      state <= S_EMPTY;
    end
  end

`ifdef ALU_RR_ARBITER_STATS_EN
  logic [7:0] grant_cnt [NREQ];
  logic [7:0] stall_cnt;

  always_ff @(posedge clk) begin
    // NOTE: the counter array is cleared by reset, so it maps to flops rather than a RAM.
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (transfer && win == IDW'(i) && grant_cnt[i] != 8'hFF)
          grant_cnt[i] <= grant_cnt[i] + 8'd1;
      end
      if (rsp_valid && !rsp_ready && stall_cnt != 8'hFF)
        stall_cnt <= stall_cnt + 8'd1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    assign stat_grants[gi*8 +: 8] = grant_cnt[gi];
  end
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_alu_rr_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int M     = 1 << WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_carry;
`ifdef ALU_RR_ARBITER_STATS_EN
  logic [NREQ*8-1:0]     stat_grants;
  logic [7:0]            stat_stall;
`endif

  always #5 clk = ~clk;

  alu_rr_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .IDW   (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry)
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot contents, priority pointer and counters as integers.
  bit              m_ok = 1'b0;
  bit              m_valid;
  int              m_id, m_res, m_carry, m_ptr;
  int              m_gr [NREQ];
  int              m_stall;
  int              w;
  bit              acc;
  int              r_res, r_carry;
  logic [NREQ-1:0] exp_ready;
  logic [NREQ-1:0] xfer_seen = '0;

  function automatic void alu_ref(input int a, input int b, input int op,
                                  output int res, output int carry);
    res = 0;
    carry = 0;
    case (op)
      0: begin res = (a + b) % M; carry = (a + b >= M) ? 1 : 0; end
      1: begin res = (a - b + M) % M; carry = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = (M - 1) - a;
      default: res = 0;
    endcase
  endfunction

  always @(negedge clk) begin
    xfer_seen = req_valid & req_ready;
    if (m_ok) begin
      acc = !m_valid || rsp_ready;
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      exp_ready = '0;
      if (w >= 0 && acc) exp_ready[w] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_result", rsp_result, m_res);
        check("rsp_carry", rsp_carry, m_carry);
      end
`ifdef ALU_RR_ARBITER_STATS_EN
      for (int i = 0; i < NREQ; i++) check("stat_grants", stat_grants[i*8 +: 8], m_gr[i]);
      check("stat_stall", stat_stall, m_stall);
`endif
    end
    if (!rst_n) begin
      m_ok = 1'b1; m_valid = 1'b0; m_id = 0; m_res = 0; m_carry = 0; m_ptr = NREQ - 1;
      for (int i = 0; i < NREQ; i++) m_gr[i] = 0;
      m_stall = 0;
    end else if (m_ok) begin
      if (m_valid && !rsp_ready && m_stall < 255) m_stall++;
      if (w >= 0 && acc) begin
        alu_ref(int'(req_a[w*WIDTH +: WIDTH]), int'(req_b[w*WIDTH +: WIDTH]),
                int'(req_op[w*3 +: 3]), r_res, r_carry);
        m_valid = 1'b1; m_id = w; m_res = r_res; m_carry = r_carry; m_ptr = w;
        if (m_gr[w] < 255) m_gr[w]++;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input int a, input int b, input int op);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    req_op[i*3 +: 3]        = 3'(op);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    step();
    step();
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_carry", rsp_carry, 1'b0);
    check("reset_req_ready", req_ready, 0);
    rst_n = 1'b1;

    // 9 + 8 = 17 -> result 1, carry 1
    set_req(0, 9, 8, 0); req_valid = 4'b0001; rsp_ready = 1'b1;
    step();
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_id", rsp_id, 0);
    check("t1_result", rsp_result, 1);
    check("t1_carry", rsp_carry, 1'b1);
    req_valid = '0;

    // All four valid: grants rotate 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1, i, 0);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_valid", rsp_valid, 1'b1);
      check("t2_id", rsp_id, k % NREQ);
    end
    req_valid = '0;
    step();

    // SUB with and without borrow
    set_req(1, 3, 5, 1); req_valid = 4'b0010;
    step();
    check("t3_id", rsp_id, 1);
    check("t3_result_borrow", rsp_result, 4'hE);
    check("t3_carry_borrow", rsp_carry, 1'b1);
    set_req(1, 5, 3, 1);
    step();
    check("t3_result", rsp_result, 2);
    check("t3_carry", rsp_carry, 1'b0);
    req_valid = '0;
    step();

    // Back-pressure: 6|3 = 7 held, then 12&10 = 8 granted in the drain cycle
    rsp_ready = 1'b0; set_req(2, 6, 3, 3); req_valid = 4'b0100;
    step();
    check("t4_fill_valid", rsp_valid, 1'b1);
    check("t4_fill_result", rsp_result, 7);
    set_req(2, 12, 10, 2);
    for (int k = 0; k < 3; k++) begin
      check("t4_stall_ready", req_ready, 0);
      step();
      check("t4_hold_valid", rsp_valid, 1'b1);
      check("t4_hold_id", rsp_id, 2);
      check("t4_hold_result", rsp_result, 7);
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_drain_ready", req_ready, 4'b0100);
    step();
    check("t4_new_id", rsp_id, 2);
    check("t4_new_result", rsp_result, 8);
    req_valid = '0;

    // Undefined opcode answered with zeros, then reset drops the held response
    set_req(3, 5, 5, 7); req_valid = 4'b1000;
    step();
    check("t5_valid", rsp_valid, 1'b1);
    check("t5_id", rsp_id, 3);
    check("t5_result", rsp_result, 0);
    check("t5_carry", rsp_carry, 1'b0);
    req_valid = '0; rsp_ready = 1'b0; rst_n = 1'b0;
    step();
    check("t5_reset_drop", rsp_valid, 1'b0);
    rst_n = 1'b1; rsp_ready = 1'b1;

`ifdef ALU_RR_ARBITER_STATS_EN
    do_reset();
    set_req(0, 1, 1, 0); req_valid = 4'b0001; rsp_ready = 1'b1;
    repeat (300) step();
    check("t6_grants_sat", stat_grants[7:0], 255);
    req_valid = '0; rsp_ready = 1'b0;
    repeat (5) step();
    check("t6_stall", stat_stall, 5);
    rsp_ready = 1'b1;
`endif

    // Randomized traffic with held payloads and occasional resets
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !xfer_seen[i])) begin
          if ($urandom_range(0, 2) != 0) begin
            req_valid[i] = 1'b1;
            set_req(i, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                    int'($urandom_range(0, 7)));
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
